// File: rtl/inexrecur_sched.sv
// Depth-first task scheduler for inexact recursive suffix-array search: a LIFO of call tuples feeds an execution unit.
// Latency: start -> first issue 1 cycle; issue handshake -> WAIT 1 cycle; last beat -> next issue 1 cycle; hit reported 1 cycle after its beat.
// Backpressure: iss_valid/iss_ready holds the stack top stable until accepted; rsp_ready is high only in WAIT, which may last indefinitely.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start, seed_*           launch a search with the root tuple (ignored unless idle)
//   iss_valid/ready, iss_*  task issue to the execution unit (stack top)
//   rsp_valid/ready, rsp_*  response beats: child push, hit report, last beat of the task
//   hit_valid, hit_k/l      one-cycle hit report
//   busy, done, err_ovf     status; err_ovf is sticky until the next accepted start
//   level                   stack occupancy
// Optional: define INEXRECUR_HIT_CNT_EN to add the 16-bit saturating hit_cnt output.

module inexrecur_sched #(
    parameter int IW    = 8,
    parameter int ZW    = 8,
    parameter int KW    = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [IW-1:0] seed_i,
    input  logic [ZW-1:0] seed_z,
    input  logic [KW-1:0] seed_k,
    input  logic [KW-1:0] seed_l,
    output logic          iss_valid,
    input  logic          iss_ready,
    output logic [IW-1:0] iss_i,
    output logic [ZW-1:0] iss_z,
    output logic [KW-1:0] iss_k,
    output logic [KW-1:0] iss_l,
    input  logic          rsp_valid,
    output logic          rsp_ready,
    input  logic          rsp_child,
    input  logic          rsp_hit,
    input  logic          rsp_last,
    input  logic [IW-1:0] rsp_i,
    input  logic [ZW-1:0] rsp_z,
    input  logic [KW-1:0] rsp_k,
    input  logic [KW-1:0] rsp_l,
    output logic          hit_valid,
    output logic [KW-1:0] hit_k,
    output logic [KW-1:0] hit_l,
    output logic          busy,
    output logic          done,
    output logic          err_ovf,
    output logic [LW-1:0] level
`ifdef INEXRECUR_HIT_CNT_EN
    ,
    output logic [15:0]   hit_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        FIN   = 2'd3
    } state_t;

    typedef struct packed {
        logic [IW-1:0] i;
        logic [ZW-1:0] z;
        logic [KW-1:0] k;
        logic [KW-1:0] l;
    } tup_t;

    tup_t          stack_mem [DEPTH];

    state_t        state_q, state_d;
    logic [LW-1:0] sp_q, sp_d;
    logic          err_ovf_q, err_ovf_d;
    logic          hit_valid_q, hit_valid_d;
    logic [KW-1:0] hit_k_q, hit_k_d;
    logic [KW-1:0] hit_l_q, hit_l_d;

    logic          push_en;
    logic [AW-1:0] push_addr;
    tup_t          push_dat;
    logic [AW-1:0] top_idx;
    tup_t          top_dat;
    logic          start_acc;

    // sp_q counts entries, so the top lives one below it; at sp_q == DEPTH
    // the low bits are zero and the subtraction lands on DEPTH-1 as intended.
    assign top_idx   = sp_q[AW-1:0] - AW'(1);
    assign top_dat   = stack_mem[top_idx];
    assign start_acc = (state_q == IDLE) && start;

    always_comb begin
        state_d     = state_q;
        sp_d        = sp_q;
        err_ovf_d   = err_ovf_q;
        hit_valid_d = 1'b0;
        hit_k_d     = hit_k_q;
        hit_l_d     = hit_l_q;
        push_en     = 1'b0;
        push_addr   = sp_q[AW-1:0];
        push_dat    = {rsp_i, rsp_z, rsp_k, rsp_l};

        case (state_q)
            IDLE: begin
                if (start) begin
                    // Stack is always empty here, so the seed goes to slot 0.
                    push_en   = 1'b1;
                    push_addr = '0;
                    push_dat  = {seed_i, seed_z, seed_k, seed_l};
                    sp_d      = LW'(1);
                    err_ovf_d = 1'b0;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (sp_q == '0) begin
                    state_d = FIN;
                end else if (iss_ready) begin
                    sp_d    = sp_q - LW'(1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (rsp_valid) begin
                    if (rsp_child) begin
                        // A full stack drops the child rather than wrapping.
                        if (sp_q == LW'(DEPTH)) begin
                            err_ovf_d = 1'b1;
                        end else begin
                            push_en = 1'b1;
                            sp_d    = sp_q + LW'(1);
                        end
                    end
                    if (rsp_hit) begin
                        hit_valid_d = 1'b1;
                        hit_k_d     = rsp_k;
                        hit_l_d     = rsp_l;
                    end
                    if (rsp_last) begin
                        state_d = ISSUE;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sp_q        <= '0;
            err_ovf_q   <= 1'b0;
            hit_valid_q <= 1'b0;
            hit_k_q     <= '0;
            hit_l_q     <= '0;
        end else begin
            state_q     <= state_d;
            sp_q        <= sp_d;
            err_ovf_q   <= err_ovf_d;
            hit_valid_q <= hit_valid_d;
            hit_k_q     <= hit_k_d;
            hit_l_q     <= hit_l_d;
        end
    end

    // Storage is not reset; the pointer alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_mem[push_addr] <= push_dat;
        end
    end

`ifdef INEXRECUR_HIT_CNT_EN
    logic [15:0] hit_cnt_q, hit_cnt_d;

    always_comb begin
        hit_cnt_d = hit_cnt_q;
        if (start_acc) begin
            hit_cnt_d = '0;
        end else if (hit_valid_q && (hit_cnt_q != 16'hFFFF)) begin
            hit_cnt_d = hit_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q <= '0;
        end else begin
            hit_cnt_q <= hit_cnt_d;
        end
    end

    assign hit_cnt = hit_cnt_q;
`endif

    // Issue payload is gated so it reads zero whenever no task is offered
    // (including during reset, when the stack storage may hold anything).
    assign iss_valid = (state_q == ISSUE) && (sp_q != '0);
    assign iss_i     = iss_valid ? top_dat.i : '0;
    assign iss_z     = iss_valid ? top_dat.z : '0;
    assign iss_k     = iss_valid ? top_dat.k : '0;
    assign iss_l     = iss_valid ? top_dat.l : '0;
    assign rsp_ready = (state_q == WAIT);
    assign busy      = (state_q == ISSUE) || (state_q == WAIT);
    assign done      = (state_q == FIN);
    assign err_ovf   = err_ovf_q;
    assign hit_valid = hit_valid_q;
    assign hit_k     = hit_k_q;
    assign hit_l     = hit_l_q;
    assign level     = sp_q;

endmodule

// File: tb/tb_inexrecur_sched.sv
// Directed bench for inexrecur_sched with a 4-entry stack.
// Latency: checks are taken 1 time unit after each rising edge.
// Backpressure: exercises iss_ready stalls and response-side overflow.

module tb_inexrecur_sched;

    localparam int IW = 8, ZW = 8, KW = 8, DEPTH = 4, LW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [IW-1:0] seed_i = '0;
    logic [ZW-1:0] seed_z = '0;
    logic [KW-1:0] seed_k = '0;
    logic [KW-1:0] seed_l = '0;
    logic          iss_valid;
    logic          iss_ready = 1'b0;
    logic [IW-1:0] iss_i;
    logic [ZW-1:0] iss_z;
    logic [KW-1:0] iss_k;
    logic [KW-1:0] iss_l;
    logic          rsp_valid = 1'b0;
    logic          rsp_ready;
    logic          rsp_child = 1'b0;
    logic          rsp_hit = 1'b0;
    logic          rsp_last = 1'b0;
    logic [IW-1:0] rsp_i = '0;
    logic [ZW-1:0] rsp_z = '0;
    logic [KW-1:0] rsp_k = '0;
    logic [KW-1:0] rsp_l = '0;
    logic          hit_valid;
    logic [KW-1:0] hit_k;
    logic [KW-1:0] hit_l;
    logic          busy;
    logic          done;
    logic          err_ovf;
    logic [LW-1:0] level;
`ifdef INEXRECUR_HIT_CNT_EN
    logic [15:0]   hit_cnt;
`endif

    int n_vec = 0;
    int n_bad = 0;

    inexrecur_sched #(.IW(IW), .ZW(ZW), .KW(KW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .seed_i(seed_i), .seed_z(seed_z), .seed_k(seed_k), .seed_l(seed_l),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_i(iss_i), .iss_z(iss_z), .iss_k(iss_k), .iss_l(iss_l),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_child(rsp_child), .rsp_hit(rsp_hit), .rsp_last(rsp_last),
        .rsp_i(rsp_i), .rsp_z(rsp_z), .rsp_k(rsp_k), .rsp_l(rsp_l),
        .hit_valid(hit_valid), .hit_k(hit_k), .hit_l(hit_l),
        .busy(busy), .done(done), .err_ovf(err_ovf), .level(level)
`ifdef INEXRECUR_HIT_CNT_EN
        , .hit_cnt(hit_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] i, input logic [7:0] z,
                            input logic [7:0] k, input logic [7:0] l);
        seed_i = i; seed_z = z; seed_k = k; seed_l = l;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic beat(input logic c, input logic h, input logic la,
                        input logic [7:0] i, input logic [7:0] z,
                        input logic [7:0] k, input logic [7:0] l);
        rsp_valid = 1'b1; rsp_child = c; rsp_hit = h; rsp_last = la;
        rsp_i = i; rsp_z = z; rsp_k = k; rsp_l = l;
        tick();
        rsp_valid = 1'b0; rsp_child = 1'b0; rsp_hit = 1'b0; rsp_last = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #3;
        chk("rst_outs", 32'({iss_valid, rsp_ready, busy, done, err_ovf, hit_valid}), 0);
        chk("rst_level", 32'(level), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single task, no children
        iss_ready = 1'b1;
        do_start(8'd3, 8'd1, 8'd0, 8'd9);
        chk("t1_iss_valid", 32'(iss_valid), 1);
        chk("t1_iss_tuple", 32'({iss_i, iss_z, iss_k, iss_l}), 32'h0301_0009);
        chk("t1_level1", 32'(level), 1);
        chk("t1_busy", 32'(busy), 1);
        tick();
        chk("t1_rsp_ready", 32'(rsp_ready), 1);
        chk("t1_level0", 32'(level), 0);
        chk("t1_no_reissue", 32'(iss_valid), 0);
        beat(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 8'd0);
        chk("t1_issue_empty", 32'({busy, iss_valid}), 32'b10);
        tick();
        chk("t1_fin", 32'({done, busy, level}), 32'b1_0_000);
        tick();
        chk("t1_idle", 32'({done, busy}), 0);

        // LIFO ordering of children
        do_start(8'd3, 8'd1, 8'd0, 8'd9);
        tick();
        beat(1'b1, 1'b0, 1'b0, 8'd2, 8'd1, 8'd1, 8'd4);
        chk("t2_level_a", 32'(level), 1);
        beat(1'b1, 1'b0, 1'b0, 8'd2, 8'd0, 8'd5, 8'd7);
        chk("t2_level_b", 32'(level), 2);
        beat(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 8'd0);
        chk("t2_first", 32'({iss_i, iss_z, iss_k, iss_l}), 32'h0200_0507);
        tick();
        chk("t2_level_c", 32'(level), 1);
        beat(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 8'd0);
        chk("t2_second", 32'({iss_i, iss_z, iss_k, iss_l}), 32'h0201_0104);
        tick();
        beat(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 8'd0);
        tick();
        chk("t2_done", 32'(done), 1);
        tick();

        // Hit and child in the same beat
        do_start(8'd3, 8'd1, 8'd0, 8'd9);
        tick();
        beat(1'b1, 1'b1, 1'b0, 8'd1, 8'd0, 8'd4, 8'd6);
        chk("t3_hit_valid", 32'(hit_valid), 1);
        chk("t3_hit_kl", 32'({hit_k, hit_l}), 32'h0406);
        chk("t3_level", 32'(level), 1);
        beat(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 8'd0);
        chk("t3_hit_pulse", 32'(hit_valid), 0);
        chk("t3_child_iss", 32'({iss_i, iss_z, iss_k, iss_l}), 32'h0100_0406);
        tick();
        beat(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 8'd0);
        tick();
        tick();

        // Overflow: five children into a four-entry stack
        do_start(8'd0, 8'd0, 8'd0, 8'd0);
        tick();
        for (int n = 0; n < 5; n++) begin
            beat(1'b1, 1'b0, 1'b0, 8'(10 + n), 8'd0, 8'(n), 8'(n));
            chk($sformatf("t4_level_%0d", n), 32'(level), (n < 4) ? n + 1 : 4);
            if (n == 3) chk("t4_no_ovf_yet", 32'(err_ovf), 0);
        end
        chk("t4_ovf", 32'(err_ovf), 1);
        beat(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 8'd0);
        for (int m = 0; m < 4; m++) begin
            chk($sformatf("t4_drain_%0d", m), 32'({iss_valid, iss_i}), 32'h100 | (13 - m));
            tick();
            beat(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 8'd0);
        end
        chk("t4_empty", 32'({iss_valid, level}), 0);
        tick();
        chk("t4_fin_ovf", 32'({done, err_ovf}), 32'b11);
        tick();
        chk("t4_idle_ovf", 32'(err_ovf), 1);

        // Stall, ignored start, reset in WAIT
        iss_ready = 1'b0;
        do_start(8'd7, 8'd2, 8'd3, 8'd5);
        chk("t5_ovf_clr", 32'(err_ovf), 0);
        seed_i = 8'd9; seed_z = 8'd9; seed_k = 8'd9; seed_l = 8'd9;
        start = 1'b1;
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("t5_stall_%0d", c), 32'({iss_valid, iss_i, iss_z, iss_k, iss_l}) , 32'h0702_0305 | (iss_valid ? 32'h0 : 32'hDEAD_0000));
            tick();
        end
        start = 1'b0;
        chk("t5_stall_valid", 32'(iss_valid), 1);
        chk("t5_stall_level", 32'(level), 1);
        iss_ready = 1'b1;
        tick();
        chk("t5_wait", 32'(rsp_ready), 1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_outs", 32'({iss_valid, rsp_ready, busy, done, err_ovf, hit_valid, level}), 0);
        chk("t5_rst_data", 32'({iss_i, iss_z, iss_k, iss_l}), 0);
        chk("t5_rst_hit", 32'({hit_k, hit_l}), 0);
        tick();
        rst_n = 1'b1;
        begin
            logic seen_done;
            seen_done = 1'b0;
            for (int c = 0; c < 5; c++) begin
                tick();
                seen_done = seen_done | done | busy;
            end
            chk("t5_no_done", 32'(seen_done), 0);
        end

        // Three hits, counter where present
        do_start(8'd3, 8'd1, 8'd0, 8'd9);
        tick();
        beat(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd1, 8'd2);
        chk("t6_hit1", 32'({hit_valid, hit_k, hit_l}), 32'h1_0102);
        beat(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd2, 8'd3);
        chk("t6_hit2", 32'({hit_valid, hit_k, hit_l}), 32'h1_0203);
        beat(1'b0, 1'b1, 1'b1, 8'd0, 8'd0, 8'd3, 8'd4);
        chk("t6_hit3", 32'({hit_valid, hit_k, hit_l}), 32'h1_0304);
        tick();
        chk("t6_done", 32'(done), 1);
        tick();
`ifdef INEXRECUR_HIT_CNT_EN
        chk("t6_hit_cnt", 32'(hit_cnt), 3);
`endif
        do_start(8'd3, 8'd1, 8'd0, 8'd9);
`ifdef INEXRECUR_HIT_CNT_EN
        chk("t6_hit_cnt_clr", 32'(hit_cnt), 0);
`endif
        chk("t6_restart", 32'({busy, level}), 32'b1_001);
        tick();
        beat(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0, 8'd0);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
